sata_dma_engine: RTL and testbench

//  DMA engine directly downstream of the port DCR register block. Takes the

---
 rtl/sata_dma_engine.sv | 120 ++++++++++++
 tb/tb_sata_dma_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_dma_engine.sv
// Splits one DMA descriptor into aligned MPI bursts of at most 2^C_BURST_LOG2 words,
// with a single burst outstanding, and pulses dma_ack when the descriptor retires.
module sata_dma_engine #(
  parameter int unsigned C_BURST_LOG2 = 4,
  parameter int unsigned C_PORT       = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  dma_req,
  input  logic [31:0]           dma_address,
  input  logic [15:0]           dma_length,
  input  logic                  dma_wrt,
  output logic                  dma_ack,
  output logic                  dma_busy,
  output logic                  dma_err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [31:0]           mem_addr,
  output logic [C_BURST_LOG2:0] mem_len,
  output logic                  mem_wr,
  output logic [1:0]            mem_port,
  input  logic                  mem_done,
  input  logic                  mem_err
);
  localparam int B = C_BURST_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [29:0] cur_addr_q, cur_addr_d;
  logic [13:0] rem_q, rem_d;
  logic        wrt_q, wrt_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [B:0]  mem_len_q, mem_len_d;
  logic [B:0]  room;
  logic [B:0]  len;
  logic        unused_lsbs;

  // Words left before the next aligned burst boundary; a burst is clipped there.
  assign room = {1'b1, {B{1'b0}}} - {1'b0, cur_addr_q[B-1:0]};
  assign len  = (rem_q < 14'(room)) ? rem_q[B:0] : room;

  assign unused_lsbs = ^{dma_address[1:0], dma_length[1:0]};

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    wrt_d      = wrt_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_len_d  = mem_len_q;
    unique case (state_q)
      S_IDLE: if (dma_req) begin
        cur_addr_d = dma_address[31:2];
        rem_d      = dma_length[15:2];
        wrt_d      = dma_wrt;
        err_d      = 1'b0;
        state_d    = S_CALC;
      end
      S_CALC: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          mem_addr_d = {cur_addr_q, 2'b00};
          mem_len_d  = len;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: if (mem_gnt) begin
        cur_addr_d = cur_addr_q + 30'(mem_len_q);
        rem_d      = rem_q - 14'(mem_len_q);
        state_d    = S_WAIT;
      end
      S_WAIT: if (mem_done) begin
        // A failed burst retires the whole descriptor; later bursts are dropped.
        if (mem_err) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      wrt_q      <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      wrt_q      <= wrt_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_len_q  <= mem_len_d;
    end
  end

  assign dma_ack  = (state_q == S_DONE);
  assign dma_busy = (state_q != S_IDLE);
  assign dma_err  = err_q;
  assign mem_req  = (state_q == S_ISSUE);
  assign mem_addr = mem_addr_q;
  assign mem_len  = mem_len_q;
  assign mem_wr   = wrt_q;
  assign mem_port = 2'(C_PORT);
endmodule

// File: tb/tb_sata_dma_engine.sv
// Scoreboard bench for sata_dma_engine: a word-level burst model fills expectation
// queues, a randomized memory responder drives the command port, a monitor checks.
module tb_sata_dma_engine;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        dma_req = 1'b0;
  logic [31:0] dma_address = '0;
  logic [15:0] dma_length = '0;
  logic        dma_wrt = 1'b0;
  logic        dma_ack, dma_busy, dma_err, mem_req, mem_wr;
  logic        mem_gnt, mem_done, mem_err;
  logic [31:0] mem_addr;
  logic [4:0]  mem_len;
  logic [1:0]  mem_port;

  sata_dma_engine #(.C_BURST_LOG2(4), .C_PORT(0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .dma_req(dma_req), .dma_address(dma_address), .dma_length(dma_length), .dma_wrt(dma_wrt),
    .dma_ack(dma_ack), .dma_busy(dma_busy), .dma_err(dma_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wr(mem_wr), .mem_port(mem_port), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {logic [31:0] addr; int len; logic wr; int cyc;} burst_t;
  typedef struct {logic err; int cyc;} ack_t;

  burst_t exp_b[$];
  ack_t   exp_a[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic last_err = 1'b0;

  // responder controls
  int err_burst = -1, burst_idx = 0, gmin = 0, gmax = 0, dmax = 0, rs = 0;
  int last_done_cyc = 0;
  bit hold_done = 0, spurious = 0, rsp_flush = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: walk the word range, cutting at every 16-word aligned boundary.
  task automatic model(input logic [31:0] addr, input logic [15:0] len, input logic wr,
                       input int err_idx, input int c0, output logic err);
    longint a;
    int r, room, l, i;
    burst_t b;
    ack_t k;
    a = longint'(addr >> 2);
    r = int'(len >> 2);
    i = 0;
    err = 1'b0;
    while (r > 0) begin
      room = 16 - int'(a % 16);
      l = (r < room) ? r : room;
      b.addr = 32'(a * 4);
      b.len = l;
      b.wr = wr;
      b.cyc = (i == 0) ? c0 + 2 : -1;
      exp_b.push_back(b);
      a = (a + l) % (longint'(1) << 30);
      r -= l;
      if (i == err_idx) begin
        err = 1'b1;
        break;
      end
      i++;
    end
    k.err = err;
    k.cyc = ((len >> 2) == 0) ? c0 + 2 : -1;
    exp_a.push_back(k);
  endtask

  // Memory-side responder: grant after a random delay, then finish the burst.
  initial begin
    int cnt;
    mem_gnt = 0; mem_done = 0; mem_err = 0;
    cnt = 0;
    forever begin
      @(negedge sys_clk);
      mem_gnt = 0; mem_done = 0; mem_err = 0;
      if (rsp_flush) begin
        rs = 0;
        rsp_flush = 0;
      end else begin
        if (rs == 0 && mem_req) begin
          cnt = int'($urandom_range(gmax, gmin));
          rs = 1;
        end
        if (rs == 1) begin
          if (cnt == 0) begin
            mem_gnt = 1;
            rs = 2;
            cnt = int'($urandom_range(dmax, 0));
          end else begin
            cnt--;
            if (spurious) begin mem_done = 1; mem_err = 1'($urandom); end
          end
        end else if (rs == 2) begin
          if (hold_done) begin
            if (spurious) mem_gnt = 1;
          end else if (cnt == 0) begin
            mem_done = 1;
            mem_err = (burst_idx == err_burst);
            burst_idx++;
            last_done_cyc = cyc;
            rs = 0;
          end else begin
            cnt--;
            if (spurious) mem_gnt = 1;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a burst or an ack.
  initial begin
    bit seen, ack_prev;
    logic [31:0] ha;
    logic [4:0] hl;
    burst_t b;
    ack_t k;
    seen = 0; ack_prev = 0; ha = '0; hl = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        seen = 0;
        ack_prev = 0;
      end else begin
        if (ack_prev) chk("busy_after_ack", dma_busy, 0);
        ack_prev = dma_ack;
        if (mem_req) begin
          chk("busy_during_req", dma_busy, 1);
          if (!seen) begin
            seen = 1; ha = mem_addr; hl = mem_len;
            if (exp_b.size() == 0) fail("unexpected_burst");
            else begin
              b = exp_b.pop_front();
              chk("burst_addr", mem_addr, b.addr);
              chk("burst_len", 32'(mem_len), 32'(b.len));
              chk("burst_wr", 32'(mem_wr), 32'(b.wr));
              chk("burst_port", 32'(mem_port), 0);
              if (b.cyc >= 0) chk("req_latency", cyc, b.cyc);
            end
          end else begin
            chk("addr_held", mem_addr, ha);
            chk("len_held", 32'(mem_len), 32'(hl));
          end
        end else seen = 0;
        if (dma_ack) begin
          chk("ack_busy", dma_busy, 1);
          if (exp_a.size() == 0) fail("unexpected_ack");
          else begin
            k = exp_a.pop_front();
            chk("ack_err", 32'(dma_err), 32'(k.err));
            chk("bursts_left", exp_b.size(), 0);
            if (k.cyc >= 0) chk("ack_latency", cyc, k.cyc);
            else chk("done_to_ack", cyc, last_done_cyc + 1);
          end
        end
      end
    end
  end

  task automatic recover();
    sys_rst = 1; dma_req = 0; rsp_flush = 1; hold_done = 0;
    exp_b.delete(); exp_a.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst = 0;
    last_err = 0;
  endtask

  task automatic run_desc(input logic [31:0] addr, input logic [15:0] len, input logic wr,
                          input int err_idx, input int g0, input int g1, input int d1, input bit sp);
    logic e;
    int to;
    @(negedge sys_clk);
    chk("err_sticky", 32'(dma_err), 32'(last_err));
    chk("idle_busy", 32'(dma_busy), 0);
    err_burst = err_idx; burst_idx = 0; gmin = g0; gmax = g1; dmax = d1; spurious = sp;
    model(addr, len, wr, err_idx, cyc, e);
    dma_address = addr; dma_length = len; dma_wrt = wr; dma_req = 1;
    @(negedge sys_clk);
    dma_address = $urandom; dma_length = 16'($urandom); dma_wrt = 1'($urandom);
    to = 0;
    while (!dma_ack && to < 20000) begin
      @(negedge sys_clk);
      to++;
    end
    if (!dma_ack) begin
      fail("ack_timeout");
      recover();
    end else begin
      @(posedge sys_clk);
      #1 dma_req = 0;
      last_err = e;
      repeat (3) begin
        @(negedge sys_clk);
        chk("no_reaccept", 32'({mem_req, dma_busy}), 0);
      end
    end
  endtask

  task automatic reset_in_wait();
    logic e;
    int to, acks;
    @(negedge sys_clk);
    chk("err_sticky", 32'(dma_err), 32'(last_err));
    hold_done = 1; burst_idx = 0; err_burst = -1; gmin = 0; gmax = 2; spurious = 0;
    model(32'h2000, 16'd128, 1'b1, -1, cyc, e);
    while (exp_b.size() > 1) void'(exp_b.pop_back());
    exp_a.delete();
    dma_address = 32'h2000; dma_length = 16'd128; dma_wrt = 1; dma_req = 1;
    to = 0;
    while (rs != 2 && to < 50) begin
      @(negedge sys_clk);
      to++;
    end
    if (rs != 2) fail("grant_timeout");
    @(negedge sys_clk);
    sys_rst = 1;
    @(negedge sys_clk);
    chk("rst_ack", 32'(dma_ack), 0);
    chk("rst_busy", 32'(dma_busy), 0);
    chk("rst_err", 32'(dma_err), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_len", 32'(mem_len), 0);
    exp_b.delete();
    rsp_flush = 1; hold_done = 0; dma_req = 0;
    @(negedge sys_clk);
    sys_rst = 0;
    last_err = 0;
    acks = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (dma_ack || mem_req) acks++;
    end
    chk("quiet_after_rst", acks, 0);
  endtask

  initial begin
    logic [15:0] l;
    int ei;
    repeat (3) @(negedge sys_clk);
    chk("reset_ack", 32'(dma_ack), 0);
    chk("reset_busy", 32'(dma_busy), 0);
    chk("reset_err", 32'(dma_err), 0);
    chk("reset_req", 32'(mem_req), 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_len", 32'(mem_len), 0);
    sys_rst = 0;

    run_desc(32'h0000_1000, 16'd64,  1'b1, -1, 0, 0, 2, 0);  // single full burst
    run_desc(32'h0000_1038, 16'd100, 1'b0, -1, 0, 2, 3, 0);  // 2 + 16 + 7 words
    run_desc(32'h0000_2000, 16'd3,   1'b1, -1, 0, 1, 1, 0);  // zero words
    run_desc(32'h0000_1038, 16'd100, 1'b1,  1, 0, 2, 3, 0);  // error on second burst
    reset_in_wait();
    run_desc(32'h0000_3004, 16'd80,  1'b0, -1, 5, 5, 2, 1);  // slow grant, stray pulses
    run_desc(32'hFFFF_FFF8, 16'd40,  1'b1, -1, 0, 2, 2, 1);  // address wraps
    run_desc(32'h0000_0010, 16'hFFFF, 1'b0, -1, 0, 1, 1, 0); // largest descriptor
    for (int n = 0; n < 40; n++) begin
      l = 16'($urandom_range(400, 0));
      ei = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      run_desc($urandom, l, 1'($urandom), ei, 0, 3, 4, 1'($urandom));
    end

    repeat (3) @(negedge sys_clk);
    chk("queues_empty", 32'(exp_b.size() + exp_a.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
